// File: rtl/crc_pkg.sv
// Shared types for the streaming CRC engine: FSM states and common CRC presets.
package crc_pkg;

  localparam int unsigned PRESET_W = 32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } crc_state_e;

  typedef struct packed {
    logic [PRESET_W-1:0] poly;
    logic [PRESET_W-1:0] init;
    logic [PRESET_W-1:0] xor_out;
  } crc_preset_t;

  // Values are right-aligned; narrower CRCs take the low bits.
  localparam crc_preset_t CRC16_CCITT  = '{poly: 32'h0000_1021, init: 32'h0000_FFFF, xor_out: 32'h0000_0000};
  localparam crc_preset_t CRC16_XMODEM = '{poly: 32'h0000_1021, init: 32'h0000_0000, xor_out: 32'h0000_0000};
  localparam crc_preset_t CRC32_BZIP2  = '{poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF, xor_out: 32'hFFFF_FFFF};

endpackage

// File: rtl/crc_step.sv
// Combinational MSB-first CRC update over one DATA_W-bit beat.
module crc_step #(
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
  parameter int unsigned      DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  logic [CRC_W-1:0] r;
  logic             fb;

  always_comb begin
    r  = crc_i;
    fb = 1'b0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ data_i[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    crc_o = r;
  end

endmodule

// File: rtl/crc_stream.sv
// Framed ready/valid CRC engine; result held until consumed downstream.
// Define CRC_STREAM_RESIDUE_EN to add the RESIDUE parameter and o_match output.
module crc_stream
  import crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h1021),
  parameter logic [CRC_W-1:0] INIT    = CRC_W'(16'hFFFF),
  parameter logic [CRC_W-1:0] XOR_OUT = CRC_W'(16'h0000),
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      LEN_W   = 16
`ifdef CRC_STREAM_RESIDUE_EN
  , parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_abort,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CRC_W-1:0]  o_crc,
  output logic [LEN_W-1:0]  o_beats
`ifdef CRC_STREAM_RESIDUE_EN
  , output logic            o_match
`endif
);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, step_crc, crc_out_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             valid_q, ready_q;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .DATA_W(DATA_W)
  ) u_step (
    .crc_i (crc_q),
    .data_i(i_data),
    .crc_o (step_crc)
  );

  // Next-state: abort beats valid in ACCUM; DONE waits only for i_ready.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        if (i_abort) begin
          crc_d = INIT;
          cnt_d = '0;
        end else if (i_valid) begin
          crc_d = step_crc;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
          if (i_last) state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          crc_d   = INIT;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ACCUM;
      crc_q     <= INIT;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      crc_out_q <= INIT ^ XOR_OUT;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      valid_q   <= (state_d == DONE);
      ready_q   <= (state_d == ACCUM);
      crc_out_q <= crc_d ^ XOR_OUT;
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_crc   = crc_out_q;
  assign o_beats = cnt_q;

`ifdef CRC_STREAM_RESIDUE_EN
  logic match_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) match_q <= 1'b0;
    else         match_q <= (state_d == DONE) && (crc_d == RESIDUE);
  end

  assign o_match = match_q;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Bench for crc_stream: table-driven frames with a result scoreboard plus corner sequences.
module tb_crc_stream;
  import crc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v8, l8, ab8, rdy8;
  logic [7:0]  d8;
  logic        v1, l1, ab1, rdy1;
  logic [0:0]  d1;

  logic        a_ready, a_valid, d_ready, d_valid;
  logic [15:0] a_crc, a_beats;
  logic [31:0] d_crc;
  logic [2:0]  d_beats;
  logic        b_ready, b_valid, c_ready, c_valid;
  logic [15:0] b_crc, b_beats, c_crc, c_beats;
`ifdef CRC_STREAM_RESIDUE_EN
  logic        a_match, b_match, c_match, d_match;
`endif

  // A: CCITT bytes. D: BZIP2 bytes, 3-bit counter. B/C: bit-serial CCITT and XMODEM.
  crc_stream #(.CRC_W(16), .POLY(16'(CRC16_CCITT.poly)), .INIT(16'(CRC16_CCITT.init)),
               .XOR_OUT(16'(CRC16_CCITT.xor_out)), .DATA_W(8), .LEN_W(16)) u_a (
`ifdef CRC_STREAM_RESIDUE_EN
    .o_match(a_match),
`endif
    .i_clock(clk), .i_reset(rst), .i_valid(v8), .o_ready(a_ready), .i_data(d8), .i_last(l8),
    .i_abort(ab8), .o_valid(a_valid), .i_ready(rdy8), .o_crc(a_crc), .o_beats(a_beats));

  crc_stream #(.CRC_W(32), .POLY(CRC32_BZIP2.poly), .INIT(CRC32_BZIP2.init),
               .XOR_OUT(CRC32_BZIP2.xor_out), .DATA_W(8), .LEN_W(3)) u_d (
`ifdef CRC_STREAM_RESIDUE_EN
    .o_match(d_match),
`endif
    .i_clock(clk), .i_reset(rst), .i_valid(v8), .o_ready(d_ready), .i_data(d8), .i_last(l8),
    .i_abort(ab8), .o_valid(d_valid), .i_ready(rdy8), .o_crc(d_crc), .o_beats(d_beats));

  crc_stream #(.CRC_W(16), .POLY(16'(CRC16_CCITT.poly)), .INIT(16'(CRC16_CCITT.init)),
               .XOR_OUT(16'(CRC16_CCITT.xor_out)), .DATA_W(1), .LEN_W(16)) u_b (
`ifdef CRC_STREAM_RESIDUE_EN
    .o_match(b_match),
`endif
    .i_clock(clk), .i_reset(rst), .i_valid(v1), .o_ready(b_ready), .i_data(d1), .i_last(l1),
    .i_abort(ab1), .o_valid(b_valid), .i_ready(rdy1), .o_crc(b_crc), .o_beats(b_beats));

  crc_stream #(.CRC_W(16), .POLY(16'(CRC16_XMODEM.poly)), .INIT(16'(CRC16_XMODEM.init)),
               .XOR_OUT(16'(CRC16_XMODEM.xor_out)), .DATA_W(1), .LEN_W(16)) u_c (
`ifdef CRC_STREAM_RESIDUE_EN
    .o_match(c_match),
`endif
    .i_clock(clk), .i_reset(rst), .i_valid(v1), .o_ready(c_ready), .i_data(d1), .i_last(l1),
    .i_abort(ab1), .o_valid(c_valid), .i_ready(rdy1), .o_crc(c_crc), .o_beats(c_beats));

  typedef struct {
    int               n;
    logic [15:0][7:0] msg;
    logic [15:0]      exp_crc;
    logic [15:0]      exp_beats;
  } vec_t;

  typedef struct {
    logic [15:0] crc;
    logic [15:0] beats;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-level reference for CRC-16 with poly 0x1021, init 0xFFFF.
  function automatic logic [15:0] ref16(input logic [15:0][7:0] m, input int n);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[15] ^ m[i][b];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat8(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    v8 = 1'b1; d8 = d; l8 = last;
    do begin
      @(negedge clk);
      guard++;
    end while (!a_ready && guard < 50);
    if (!a_ready) chk("beat8_accept_timeout", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    v8 = 1'b0; l8 = 1'b0;
  endtask

  task automatic beat1(input logic d, input logic last);
    int guard;
    guard = 0;
    v1 = 1'b1; d1 = d; l1 = last;
    do begin
      @(negedge clk);
      guard++;
    end while (!b_ready && guard < 50);
    if (!b_ready) chk("beat1_accept_timeout", 32'(b_ready), 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic send8(input vec_t v);
    for (int j = 0; j < v.n; j++) begin
      if (j == v.n - 1) sb_q.push_back('{crc: v.exp_crc, beats: v.exp_beats});
      beat8(v.msg[j], j == v.n - 1);
    end
    chk("latency_valid_after_last", 32'(a_valid), 32'd1);
  endtask

  // Scoreboard: one pop per result handshake on instance A.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && a_valid && rdy8) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_result", 32'(a_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_crc", 32'(a_crc), 32'(e.crc));
          chk("sb_beats", 32'(a_beats), 32'(e.beats));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][7:0] m9, m11;
    vec_t             v;

    rst = 1'b1;
    v8 = 1'b0; l8 = 1'b0; ab8 = 1'b0; rdy8 = 1'b1; d8 = '0;
    v1 = 1'b0; l1 = 1'b0; ab1 = 1'b0; rdy1 = 1'b1; d1 = '0;

    m9 = '0;
    for (int i = 0; i < 9; i++) m9[i] = 8'h31 + 8'(i);

    tbl[0] = '{n: 9, msg: m9, exp_crc: 16'h29B1, exp_beats: 16'd9};
    tbl[1].n = 1; tbl[1].msg = '0; tbl[1].msg[0] = 8'h41;
    tbl[1].exp_crc = 16'hB915; tbl[1].exp_beats = 16'd1;
    tbl[2].n = 3; tbl[2].msg = '0; tbl[2].msg[1] = 8'hFF; tbl[2].msg[2] = 8'h80;
    tbl[2].exp_crc = ref16(tbl[2].msg, 3); tbl[2].exp_beats = 16'd3;
    tbl[3].n = 16;
    for (int i = 0; i < 16; i++) tbl[3].msg[i] = 8'($urandom_range(0, 255));
    tbl[3].exp_crc = ref16(tbl[3].msg, 16); tbl[3].exp_beats = 16'd16;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_crc", 32'(a_crc), 32'h0000_FFFF);
    chk("rst_a_beats", 32'(a_beats), 32'd0);
    chk("rst_b_crc", 32'(b_crc), 32'h0000_FFFF);
    chk("rst_c_crc", 32'(c_crc), 32'h0000_0000);
    chk("rst_d_crc", d_crc, 32'h0000_0000);
    chk("rst_d_beats", 32'(d_beats), 32'd0);
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      send8(tbl[t]);
      if (t == 0) begin
        chk("bzip2_valid", 32'(d_valid), 32'd1);
        chk("bzip2_crc", d_crc, 32'hFC89_1918);
        chk("bzip2_beats_saturated", 32'(d_beats), 32'd7);
      end
    end

    // Bit-serial frame through B (CCITT) and C (XMODEM).
    for (int i = 0; i < 9; i++)
      for (int b = 7; b >= 0; b--)
        beat1(m9[i][b], (i == 8) && (b == 0));
    chk("serial_b_valid", 32'(b_valid), 32'd1);
    chk("serial_b_crc", 32'(b_crc), 32'h0000_29B1);
    chk("serial_b_beats", 32'(b_beats), 32'd72);
    chk("serial_c_crc", 32'(c_crc), 32'h0000_31C3);
    chk("serial_c_beats", 32'(c_beats), 32'd72);

    // Backpressure in DONE with a beat and an abort waiting at the input.
    rdy8 = 1'b0;
    send8(tbl[0]);
    v8 = 1'b1; d8 = 8'hA5; l8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ab8 = (k == 2);
      @(negedge clk);
      chk("bp_valid", 32'(a_valid), 32'd1);
      chk("bp_ready", 32'(a_ready), 32'd0);
      chk("bp_crc", 32'(a_crc), 32'h0000_29B1);
      chk("bp_beats", 32'(a_beats), 32'd9);
      @(posedge clk); #1;
    end
    ab8 = 1'b0;
    rdy8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; l8 = 1'b0;
    chk("release_no_beat_taken", 32'(a_beats), 32'd0);
    chk("release_ready", 32'(a_ready), 32'd1);
    chk("release_crc_init", 32'(a_crc), 32'h0000_FFFF);
    send8(tbl[0]);

    // Abort after four beats, with a simultaneous beat that must be dropped.
    for (int j = 0; j < 4; j++) beat8(m9[j], 1'b0);
    v8 = 1'b1; d8 = 8'h55; ab8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; ab8 = 1'b0;
    chk("abort_beats", 32'(a_beats), 32'd0);
    chk("abort_crc", 32'(a_crc), 32'h0000_FFFF);
    send8(tbl[0]);

    // Reset mid-frame.
    for (int j = 0; j < 4; j++) beat8(m9[j], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_beats", 32'(a_beats), 32'd0);
    chk("midrst_crc", 32'(a_crc), 32'h0000_FFFF);
    chk("midrst_valid", 32'(a_valid), 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd1);
    send8(tbl[0]);

`ifdef CRC_STREAM_RESIDUE_EN
    m11 = m9; m11[9] = 8'h29; m11[10] = 8'hB1;
    v = '{n: 11, msg: m11, exp_crc: 16'h0000, exp_beats: 16'd11};
    send8(v);
    chk("residue_match", 32'(a_match), 32'd1);
    m11[10] = 8'hB0;
    v = '{n: 11, msg: m11, exp_crc: ref16(m11, 11), exp_beats: 16'd11};
    send8(v);
    chk("residue_corrupt_nomatch", 32'(a_match), 32'd0);
`else
    m11 = '0;
    v = '{n: 0, msg: m11, exp_crc: 16'h0, exp_beats: 16'h0};
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
Parametrised successor to the team's fixed CRC-16-CCITT serial engine. Computes an MSB-first CRC of any width and polynomial over a framed stream, DATA_W bits per clock. Uses ready/valid handshakes on input and output, marks frame end with i_last, and holds the result until it is consumed. Sits between a byte/word source (UART/SPI/packet framer) and the downstream checker or transmitter.

Parameters:
CRC_W, 16, CRC register width (8..32)
POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted
INIT, 16'hFFFF, register value at start of every frame
XOR_OUT, 16'h0000, XOR applied to register to form o_crc
DATA_W, 8, bits consumed per accepted beat (1..32)
LEN_W, 16, width of beat counter

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  input beat valid
o_ready  out  1  engine can accept a beat
i_data  in  DATA_W  beat data; bit DATA_W-1 is processed first
i_last  in  1  beat is final beat of frame
i_abort  in  1  discard frame in progress
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_crc  out  CRC_W  final CRC (register XOR XOR_OUT)
o_beats  out  LEN_W  beats in completed frame, saturating

Behaviour:
- Reset (i_reset=1 at clock edge): state=ACCUM, crc_reg=INIT, beat count=0, o_valid=0, o_ready=1, o_crc=INIT^XOR_OUT, o_beats=0. Reset mid-frame or mid-DONE discards everything.
- States: ACCUM (o_ready=1, o_valid=0) and DONE (o_ready=0, o_valid=1).
- ACCUM: on i_valid&o_ready, crc_reg <= step(crc_reg, i_data) and count <= count+1, saturating at 2^LEN_W-1. If i_last is also set, go to DONE next cycle. Latency from last-beat accept to o_valid=1 is 1 cycle.
- step: loop over DATA_W bits, MSB first: fb = reg[CRC_W-1]^d; reg = (reg<<1) ^ (fb ? POLY : 0), truncated to CRC_W.
- DONE: o_crc and o_beats stay stable while o_valid=1 and i_ready=0. On i_ready=1: crc_reg<=INIT, count<=0, return to ACCUM. No input beat is accepted in this cycle.
- i_valid while o_ready=0 is ignored; the source must hold the beat.
- i_abort in ACCUM: crc_reg<=INIT, count<=0, and any simultaneous beat is dropped. i_abort has priority over i_valid. i_abort in DONE is ignored.
- A single-beat frame (i_valid&i_last on the first beat) is legal and gives o_beats=1.
- o_crc and o_beats are registered outputs, with no combinational path from inputs.

Optional Feature:
CRC_STREAM_RESIDUE_EN: adds parameter RESIDUE (default 0) and output o_match (1 bit). o_match is high in DONE when crc_reg (before XOR_OUT) == RESIDUE, and is 0 otherwise. Its reset value is 0. This lets a receiver push message+appended CRC through the engine and read pass/fail directly. Without the macro, the port and parameter do not exist and the logic is otherwise identical.

Decomposition:
- Package crc_pkg: state enum (ACCUM, DONE) and named preset constants: CRC16_CCITT (1021/FFFF/0000), CRC16_XMODEM (1021/0000/0000), CRC32_BZIP2 (04C11DB7/FFFFFFFF/FFFFFFFF).
- Sub-module crc_step: purely combinational DATA_W-bit update, parameters CRC_W/POLY/DATA_W. It is reusable by future parallel or LFSR blocks.

Test Plan:
- CCITT defaults, DATA_W=8, "123456789" (0x31..0x39) with last on 0x39 -> o_valid 1 cycle after last beat, o_crc=16'h29B1, o_beats=9.
- DATA_W=1, same message fed bit-serially MSB-first (72 beats) -> o_crc=16'h29B1, o_beats=72. Repeat with INIT=0 -> 16'h31C3.
- CRC32_BZIP2 preset, DATA_W=8, "123456789" -> o_crc=32'hFC891918.
- Backpressure: hold i_ready=0 for 5 cycles in DONE with i_valid=1 -> o_crc stable, o_ready=0, no beats consumed. Then i_ready=1 -> next frame "123456789" again gives 16'h29B1.
- i_abort after 4 beats ("1234"), then full "123456789" -> 16'h29B1, o_beats=9. Assert i_reset mid-frame -> same result on a restarted frame.
- RESIDUE_EN, CCITT: feed "123456789",0x29,0xB1 -> o_match=1. Corrupt one bit -> o_match=0.
